// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0] BCD_ADJ        = 4'd3;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/busy/done handshake and data bus of the BCD-to-binary converter.
interface bcd2bin_seq_if #(
    parameter int unsigned D = 5,
    parameter int unsigned W = 16
);

    logic             start;
    logic [4*D-1:0]   bcd;
    logic             busy;
    logic             done;
    logic [W-1:0]     bin;
    logic             ovf;
    logic             err;

    modport master (output start, bcd, input busy, done, bin, ovf, err);
    modport slave  (input start, bcd, output busy, done, bin, ovf, err);

endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: digits >= 8 after a right shift lose 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] adj_c_o
);

    // Subtract within the nibble only; no borrow leaves the digit.
    assign adj_c_o = (d_i >= BCD_ADJ_THRESH) ? (d_i - BCD_ADJ) : d_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble step per clock.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned D = 5,
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst,
    bcd2bin_seq_if.slave   bus
);

    localparam int unsigned BW = 4 * D;
    localparam int unsigned SW = 8 * D;
    localparam int unsigned CW = $clog2(BW + 1);
    localparam int unsigned XW = (BW > W) ? BW : W;

    state_e          state_q, state_d;
    logic [SW-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic [W-1:0]    bin_q, bin_d;

    logic [SW-1:0]   shifted_c;
    logic [BW-1:0]   upper_adj_c;
    logic            bad_digit_c;
    logic [XW-1:0]   low_ext_c;
    logic            low_ovf_c;

    assign shifted_c = sreg_q >> 1;

    // Correct every BCD digit of the upper half after the shift.
    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i     (shifted_c[BW + 4*g +: 4]),
            .adj_c_o (upper_adj_c[4*g +: 4])
        );
    end

    // Flag any input digit outside 0..9.
    always_comb begin
        bad_digit_c = 1'b0;
        for (int unsigned i = 0; i < D; i++) begin
            if (bus.bcd[4*i +: 4] > BCD_MAX_DIGIT) begin
                bad_digit_c = 1'b1;
            end
        end
    end

    // Binary field widened so bits above W can be tested for saturation.
    assign low_ext_c = XW'(sreg_q[BW-1:0]);
    assign low_ovf_c = (low_ext_c >> W) != '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = bad_digit_c ? ST_FIN : ST_SHIFT;
            ST_SHIFT: if (cnt_q == CW'(1)) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values per state.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        bin_d  = bin_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    sreg_d = {bus.bcd, {BW{1'b0}}};
                    cnt_d  = CW'(BW);
                    ovf_d  = 1'b0;
                    err_d  = bad_digit_c;
                    busy_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                sreg_d = {upper_adj_c, shifted_c[BW-1:0]};
                cnt_d  = cnt_q - CW'(1);
            end
            ST_FIN: begin
                done_d = 1'b1;
                busy_d = 1'b1;
                if (err_q) begin
                    bin_d = '0;
                    ovf_d = 1'b0;
                end else if (low_ovf_c) begin
                    bin_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    bin_d = low_ext_c[W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bin_q  <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            bin_q  <= bin_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bin  = bin_q;
    assign bus.ovf  = ovf_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq against a decimal-arithmetic reference.
module tb_bcd2bin_seq;

    localparam int unsigned D  = 5;
    localparam int unsigned W  = 16;
    localparam int unsigned BW = 4 * D;
    localparam int LAT  = 4 * D + 1;
    localparam int GAP  = 4 * D + 2;
    localparam int NRND = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd2bin_seq_if #(.D(D), .W(W)) bus ();

    bcd2bin_seq #(.D(D), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal value of the digits, saturated to W bits; invalid digits give an error.
    function automatic void ref_conv(input logic [BW-1:0] b, output logic [W-1:0] eb,
                                     output logic eo, output logic ee);
        longint v;
        v  = 0;
        ee = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            int d;
            d = int'(b[i*4 +: 4]);
            if (d > 9) ee = 1'b1;
            v = v * 10 + d;
        end
        if (ee) begin
            eb = '0;
            eo = 1'b0;
        end else if (v >= (longint'(1) << W)) begin
            eb = '1;
            eo = 1'b1;
        end else begin
            eb = W'(v);
            eo = 1'b0;
        end
    endfunction

    // Binary-to-BCD by repeated division.
    function automatic logic [BW-1:0] to_bcd(input longint v);
        logic [BW-1:0] r;
        longint t;
        r = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // One pulse of start, then wait (bounded) for done; lat = edges after the accepting edge.
    task automatic conv(input logic [BW-1:0] b, output int lat);
        bus.start = 1'b1;
        bus.bcd   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.bcd   = BW'($urandom);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.bcd   = '0;
        rst = 1'b1;
        #12;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.bin !== 16'h0) begin n_fail++; $display("FAIL reset_bin: got %h want 0", bus.bin); end
        n_checks++; if ({bus.ovf, bus.err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {bus.ovf, bus.err}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat;
        conv(20'h00000, lat);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (bus.bin !== 16'h0) begin n_fail++; $display("FAIL zero_bin: got %h want 0", bus.bin); end
        n_checks++; if ({bus.ovf, bus.err} !== 2'b00) begin n_fail++; $display("FAIL zero_flags: got %b want 00", {bus.ovf, bus.err}); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_at_done: got %b want 1", bus.busy); end
        @(posedge clk); #1;
        n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL zero_after_done: got busy,done=%b want 00", {bus.busy, bus.done}); end
    endtask

    task automatic test_saturate();
        logic [BW-1:0] vec [3];
        logic [W-1:0]  eb;
        logic          eo, ee;
        int            lat;
        vec[0] = 20'h65535;
        vec[1] = 20'h65536;
        vec[2] = 20'h99999;
        for (int i = 0; i < 3; i++) begin
            ref_conv(vec[i], eb, eo, ee);
            conv(vec[i], lat);
            n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL sat_latency[%h]: got %0d want %0d", vec[i], lat, LAT); end
            n_checks++; if (bus.bin !== eb) begin n_fail++; $display("FAIL sat_bin[%h]: got %h want %h", vec[i], bus.bin, eb); end
            n_checks++; if (bus.ovf !== eo) begin n_fail++; $display("FAIL sat_ovf[%h]: got %b want %b", vec[i], bus.ovf, eo); end
            n_checks++; if (bus.err !== ee) begin n_fail++; $display("FAIL sat_err[%h]: got %b want %b", vec[i], bus.err, ee); end
        end
    endtask

    task automatic test_error();
        int lat;
        conv(20'h1A234, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL err_latency: got %0d want 1", lat); end
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", bus.err); end
        n_checks++; if (bus.bin !== 16'h0) begin n_fail++; $display("FAIL err_bin: got %h want 0", bus.bin); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL err_ovf: got %b want 0", bus.ovf); end
        conv(20'h01234, lat);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL err_next_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (bus.bin !== 16'd1234) begin n_fail++; $display("FAIL err_next_bin: got %0d want 1234", bus.bin); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_next_cleared: got %b want 0", bus.err); end
    endtask

    task automatic test_ignored_start();
        int dones;
        int lat;
        dones = 0;
        lat   = -1;
        bus.start = 1'b1;
        bus.bcd   = 20'h00042;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                lat = n;
            end
            bus.start = (n == 4);
            if (n == 4) bus.bcd = 20'h09999;
        end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (bus.bin !== 16'd42) begin n_fail++; $display("FAIL ignore_bin_held: got %0d want 42", bus.bin); end
    endtask

    task automatic test_reset_mid();
        int dones;
        int lat;
        bus.start = 1'b1;
        bus.bcd   = 20'h05555;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        #3;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_busy_done: got %b want 00", {bus.busy, bus.done}); end
        n_checks++; if (bus.bin !== 16'h0) begin n_fail++; $display("FAIL rstmid_bin: got %h want 0", bus.bin); end
        n_checks++; if ({bus.ovf, bus.err} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flags: got %b want 00", {bus.ovf, bus.err}); end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
        conv(20'h04321, lat);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rstmid_fresh_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (bus.bin !== 16'd4321) begin n_fail++; $display("FAIL rstmid_fresh_bin: got %0d want 4321", bus.bin); end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] cur;
        logic [W-1:0]  eb;
        logic          eo, ee;
        int            prev, val, lat;
        prev = -1;
        val  = int'($urandom_range(0, 99999));
        cur  = to_bcd(longint'(val));
        bus.bcd   = cur;
        bus.start = 1'b1;
        for (int i = 0; i < NRND; i++) begin
            lat = -1;
            for (int n = 1; n <= 60; n++) begin
                @(posedge clk); #1;
                if (bus.done) begin
                    lat = n;
                    break;
                end
            end
            n_checks++;
            if (lat < 0) begin
                n_fail++;
                $display("FAIL b2b_timeout[%0d]: no done within 60 cycles", i);
                break;
            end
            ref_conv(cur, eb, eo, ee);
            n_checks++; if (bus.bin !== eb) begin n_fail++; $display("FAIL b2b_bin[%0d] bcd=%h: got %h want %h", i, cur, bus.bin, eb); end
            n_checks++; if ({bus.ovf, bus.err} !== {eo, ee}) begin n_fail++; $display("FAIL b2b_flags[%0d] bcd=%h: got %b want %b", i, cur, {bus.ovf, bus.err}, {eo, ee}); end
            if (!eo) begin
                n_checks++; if (to_bcd(longint'(bus.bin)) !== cur) begin n_fail++; $display("FAIL b2b_roundtrip[%0d]: got %h want %h", i, to_bcd(longint'(bus.bin)), cur); end
            end
            if (prev >= 0) begin
                n_checks++; if (cyc - prev !== GAP) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, cyc - prev, GAP); end
            end
            prev = cyc;
            val  = int'($urandom_range(0, 99999));
            cur  = to_bcd(longint'(val));
            bus.bcd = cur;
            if (i == NRND - 1) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_saturate();
        test_error();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
